// File: rtl/buffer_fifo_pkg.sv
// rtl/buffer_fifo_pkg.sv - shared constants and helpers for buffer_fifo
// Purpose: out-queue depth and level-counter width used by the FIFO, its interface and bench.
// Ports: none (package).
package buffer_fifo_pkg;

    // Words held in the registered output queue in front of the RAM.
    localparam int OUTQ_DEPTH = 2;

    // Level counter must hold 0 .. 2**aw + OUTQ_DEPTH words: aw+1 bits would do,
    // one spare bit keeps headroom for a deeper out queue without changing the port.
    function automatic int level_width(input int aw);
        return $clog2(2 ** aw) + 2;
    endfunction

endpackage

// File: rtl/buffer_fifo_if.sv
// rtl/buffer_fifo_if.sv - write/read handshake bundle for buffer_fifo
// Purpose: groups the producer and consumer valid/ready/data signals.
// Signals (named from the FIFO's point of view):
//   wr_valid_i, wr_data_i, wr_ready_o   producer side
//   rd_valid_o, rd_data_o, rd_ready_i   consumer side
//   level_o, almost_full_o              only when BUFFER_FIFO_LEVEL_EN is defined
// Modports: slave = FIFO, master = producer/consumer.
interface buffer_fifo_if
    import buffer_fifo_pkg::*;
#(
    parameter int G_BUF_DATA_WIDTH = 8
`ifdef BUFFER_FIFO_LEVEL_EN
    , parameter int G_BUF_ADDR_WIDTH = 10
`endif
);
    logic                        wr_valid_i;
    logic                        wr_ready_o;
    logic [G_BUF_DATA_WIDTH-1:0] wr_data_i;
    logic                        rd_valid_o;
    logic                        rd_ready_i;
    logic [G_BUF_DATA_WIDTH-1:0] rd_data_o;
`ifdef BUFFER_FIFO_LEVEL_EN
    logic [level_width(G_BUF_ADDR_WIDTH)-1:0] level_o;
    logic                                     almost_full_o;
`endif

    modport slave (
        input  wr_valid_i,
        input  wr_data_i,
        input  rd_ready_i,
        output wr_ready_o,
        output rd_valid_o,
        output rd_data_o
`ifdef BUFFER_FIFO_LEVEL_EN
        , output level_o
        , output almost_full_o
`endif
    );

    modport master (
        output wr_valid_i,
        output wr_data_i,
        output rd_ready_i,
        input  wr_ready_o,
        input  rd_valid_o,
        input  rd_data_o
`ifdef BUFFER_FIFO_LEVEL_EN
        , input level_o
        , input almost_full_o
`endif
    );
endinterface

// File: rtl/buffer.sv
// rtl/buffer.sv - simple dual-port RAM with registered read
// Purpose: storage behind buffer_fifo; a read returns the old word on a same-address write.
// Ports: clk_i; wr_en_i/wr_addr_i/wr_data_i write port; rd_en_i/rd_addr_i read request,
//        rd_data_o valid the cycle after rd_en_i.
module buffer #(
    parameter int G_BUF_ADDR_WIDTH = 10,
    parameter int G_BUF_DATA_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        wr_en_i,
    input  logic [G_BUF_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [G_BUF_DATA_WIDTH-1:0] wr_data_i,
    input  logic                        rd_en_i,
    input  logic [G_BUF_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [G_BUF_DATA_WIDTH-1:0] rd_data_o
);
    logic [G_BUF_DATA_WIDTH-1:0] mem_q [2**G_BUF_ADDR_WIDTH];
    logic [G_BUF_DATA_WIDTH-1:0] rd_data_q;

    // No reset: contents are never observable before being written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/buffer_fifo.sv
// rtl/buffer_fifo.sv - show-ahead FIFO: RAM plus 2-entry registered output queue
// Purpose: valid/ready buffering stage, capacity 2**G_BUF_ADDR_WIDTH + 2 words,
//          3-cycle empty latency, 1 word/cycle sustained.
// Ports: clk_i, rst_i (async, active-high); bus (buffer_fifo_if.slave) carrying the
//        write/read handshakes and, with BUFFER_FIFO_LEVEL_EN, level_o/almost_full_o.
// Config macro: BUFFER_FIFO_LEVEL_EN enables the level_o/almost_full_o logic.
module buffer_fifo
    import buffer_fifo_pkg::*;
#(
    parameter int G_BUF_ADDR_WIDTH = 10,
    parameter int G_BUF_DATA_WIDTH = 8
`ifdef BUFFER_FIFO_LEVEL_EN
    , parameter int G_AFULL_THRESH = 2**G_BUF_ADDR_WIDTH - 4
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    buffer_fifo_if.slave  bus
);
    localparam int AW = G_BUF_ADDR_WIDTH;
    localparam int DW = G_BUF_DATA_WIDTH;

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   ram_cnt, ram_cnt_d;
    logic          pend_q, pend_d;
    logic [1:0]    out_cnt_q, out_cnt_d;
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic [DW-1:0] ram_rd_data;
    logic [2:0]    out_occ;
    logic          full, push, pop, fetch;

    // Extra pointer MSB distinguishes full (D) from empty (0).
    assign ram_cnt = wptr_q - rptr_q;
    assign full    = ram_cnt[AW];
    assign push    = bus.wr_valid_i && !full;
    assign pop     = (out_cnt_q != 2'd0) && bus.rd_ready_i;

    // Slots the out queue will have claimed after this edge; a fetch only when
    // the returning word is guaranteed a register to land in.
    assign out_occ = {1'b0, out_cnt_q} + {2'b00, pend_q} - {2'b00, pop};
    assign fetch   = (ram_cnt != '0) && (out_occ < 3'(OUTQ_DEPTH));

    always_comb begin
        wptr_d    = wptr_q + {{AW{1'b0}}, push};
        rptr_d    = rptr_q + {{AW{1'b0}}, fetch};
        ram_cnt_d = wptr_d - rptr_d;
        pend_d    = fetch;
        head_d    = head_q;
        tail_d    = tail_q;
        out_cnt_d = out_cnt_q;
        case ({pend_q, pop})
            2'b01: begin
                head_d    = tail_q;
                out_cnt_d = out_cnt_q - 2'd1;
            end
            2'b10: begin
                if (out_cnt_q == 2'd0) begin
                    head_d = ram_rd_data;
                end else begin
                    tail_d = ram_rd_data;
                end
                out_cnt_d = out_cnt_q + 2'd1;
            end
            2'b11: begin
                if (out_cnt_q == 2'd1) begin
                    head_d = ram_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = ram_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            pend_q    <= 1'b0;
            out_cnt_q <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            pend_q    <= pend_d;
            out_cnt_q <= out_cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

    buffer #(
        .G_BUF_ADDR_WIDTH (AW),
        .G_BUF_DATA_WIDTH (DW)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (push),
        .wr_addr_i (wptr_q[AW-1:0]),
        .wr_data_i (bus.wr_data_i),
        .rd_en_i   (fetch),
        .rd_addr_i (rptr_q[AW-1:0]),
        .rd_data_o (ram_rd_data)
    );

    assign bus.wr_ready_o = !full;
    assign bus.rd_valid_o = (out_cnt_q != 2'd0);
    assign bus.rd_data_o  = head_q;

`ifdef BUFFER_FIFO_LEVEL_EN
    localparam int LW = level_width(AW);

    logic [LW-1:0] level_q, level_d;
    logic          afull_q;

    assign level_d = LW'(ram_cnt_d) + LW'(pend_d) + LW'(out_cnt_d);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_d;
            afull_q <= (level_d >= LW'(G_AFULL_THRESH));
        end
    end

    assign bus.level_o       = level_q;
    assign bus.almost_full_o = afull_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^ram_cnt_d;
`endif
endmodule

// File: tb/tb_buffer_fifo.sv
// tb/tb_buffer_fifo.sv - self-checking bench for buffer_fifo (AW=4, D=16, capacity 18)
module tb_buffer_fifo;
    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int CAP = 2**AW + 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] model_q[$];
    logic          hold_prev;
    logic [DW-1:0] hold_data;

    buffer_fifo_if #(
        .G_BUF_DATA_WIDTH (DW)
`ifdef BUFFER_FIFO_LEVEL_EN
        , .G_BUF_ADDR_WIDTH (AW)
`endif
    ) bus ();

    buffer_fifo #(
        .G_BUF_ADDR_WIDTH (AW),
        .G_BUF_DATA_WIDTH (DW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rr,
                         output logic did_push, output logic did_pop);
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_ready_i = rr;
        if (hold_prev) begin
            check("hold_valid", 32'(bus.rd_valid_o), 32'd1);
            check("hold_data", 32'(bus.rd_data_o), 32'(hold_data));
        end
        if (bus.rd_valid_o) begin
            if (model_q.size() == 0) check("rd_spurious", 32'd1, 32'd0);
            else check("rd_data", 32'(bus.rd_data_o), 32'(model_q[0]));
        end
        if (model_q.size() <= CAP - 2) check("wr_ready_room", 32'(bus.wr_ready_o), 32'd1);
        did_push  = wv && bus.wr_ready_o;
        did_pop   = rr && bus.rd_valid_o;
        hold_prev = bus.rd_valid_o && !rr;
        hold_data = bus.rd_data_o;
        if (did_pop && model_q.size() > 0) void'(model_q.pop_front());
        if (did_push) model_q.push_back(wd);
        @(posedge clk);
        @(negedge clk);
        if (model_q.size() > CAP) check("capacity", model_q.size(), CAP);
`ifdef BUFFER_FIFO_LEVEL_EN
        check("level", 32'(bus.level_o), 32'(model_q.size()));
`endif
    endtask

    task automatic idle(input logic rr);
        logic p, q;
        cycle(1'b0, '0, rr, p, q);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (model_q.size() != 0 || bus.rd_valid_o); i++) idle(1'b1);
        check({tag, "_empty"}, model_q.size(), 0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid_o), 32'd0);
    endtask

    // Push one word into an empty FIFO and check the 3-cycle latency, then pop it.
    task automatic latency_probe(input logic [DW-1:0] d, input string tag);
        logic p, q;
        cycle(1'b1, d, 1'b0, p, q);
        check({tag, "_accepted"}, 32'(p), 32'd1);
        check({tag, "_c1_valid"}, 32'(bus.rd_valid_o), 32'd0);
        idle(1'b0);
        check({tag, "_c2_valid"}, 32'(bus.rd_valid_o), 32'd0);
        idle(1'b0);
        check({tag, "_c3_valid"}, 32'(bus.rd_valid_o), 32'd1);
        check({tag, "_c3_data"}, 32'(bus.rd_data_o), 32'(d));
        cycle(1'b0, '0, 1'b1, p, q);
        check({tag, "_popped"}, 32'(q), 32'd1);
    endtask

    initial begin
        logic p, q;
        int   first_pop, pops, acc, prob_w, prob_r;

        n_checks  = 0;
        n_fail    = 0;
        hold_prev = 1'b0;
        hold_data = '0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
        check("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data_o), 32'd0);
`ifdef BUFFER_FIFO_LEVEL_EN
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_afull", 32'(bus.almost_full_o), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        latency_probe(8'hA5, "single");

        // Streaming: both sides always ready.
        first_pop = -1;
        pops      = 0;
        for (int c = 0; c < 1003; c++) begin
            if (c < 1000) check("stream_wr_ready", 32'(bus.wr_ready_o), 32'd1);
            cycle(c < 1000, DW'(c), 1'b1, p, q);
            if (q) begin
                if (first_pop < 0) first_pop = c;
                pops++;
            end
        end
        check("stream_first_pop", first_pop, 3);
        check("stream_pops", pops, 1000);
        drain("stream");

        // Fill with the consumer stalled.
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            cycle(1'b1, DW'($urandom), 1'b0, p, q);
            if (p) acc++;
        end
        check("fill_accepted", acc, CAP);
        check("fill_wr_ready", 32'(bus.wr_ready_o), 32'd0);
`ifdef BUFFER_FIFO_LEVEL_EN
        check("fill_afull", 32'(bus.almost_full_o), 32'd1);
`endif
        cycle(1'b1, 8'h77, 1'b1, p, q);
        check("full_push_refused", 32'(p), 32'd0);
        check("full_pop_taken", 32'(q), 32'd1);
        check("full_wr_ready_back", 32'(bus.wr_ready_o), 32'd1);
        drain("fill");

        // Random toggling on both sides, with changing bias.
        for (int c = 0; c < 10000; c++) begin
            if (c % 1000 == 0) begin
                prob_w = $urandom_range(20, 90);
                prob_r = $urandom_range(20, 90);
            end
            cycle($urandom_range(0, 99) < prob_w, DW'($urandom),
                  $urandom_range(0, 99) < prob_r, p, q);
        end
        drain("random");

        // Pointer wrap with occupancy held around 6.
        acc = 0;
        for (int c = 0; c < 400 && acc < 50; c++) begin
            cycle(1'b1, DW'(8'h40 + acc), model_q.size() >= 6, p, q);
            if (p) acc++;
        end
        check("wrap_pushed", acc, 50);
        drain("wrap");

        // Asynchronous reset mid-stream.
        for (int c = 0; c < 9; c++) cycle(1'b1, DW'(8'h90 + c), 1'b0, p, q);
`ifdef BUFFER_FIFO_LEVEL_EN
        check("pre_rst_level", 32'(bus.level_o), 32'd9);
`endif
        bus.wr_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_wr_ready", 32'(bus.wr_ready_o), 32'd1);
        check("arst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        check("arst_rd_data", 32'(bus.rd_data_o), 32'd0);
`ifdef BUFFER_FIFO_LEVEL_EN
        check("arst_level", 32'(bus.level_o), 32'd0);
        check("arst_afull", 32'(bus.almost_full_o), 32'd0);
`endif
        model_q.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        latency_probe(8'h3C, "post_rst");
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
